// File: rtl/counter_pkg.sv
// Shared encodings for the programmable counter family: terminal-mode and FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/prog_mod_counter.sv
// Up/down counter against a runtime modulus with load and wrap/saturate/one-shot terminal modes.
module prog_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;
  cnt_state_e       state_q, state_d;
  cnt_mode_e        mode_e;
  logic [WIDTH-1:0] up_clamp;
  logic             count_ok;

  assign mode_e   = cnt_mode_e'(mode);
  assign tc       = up_dn ? (count_q >= max_val) : (count_q == '0);
  // Terminal hold value when counting up: pulls an out-of-range count back to max_val.
  assign up_clamp = (count_q > max_val) ? max_val : count_q;

  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    sat_d    = sat_q;
    done_d   = done_q;
    state_d  = state_q;
    count_ok = 1'b0;

    if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
      sat_d   = 1'b0;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else begin
      if (state_q == ST_DONE) begin
        // Leaving one-shot mode releases the freeze immediately.
        if (mode_e != CNT_ONESHOT) begin
          done_d   = 1'b0;
          state_d  = ST_RUN;
          count_ok = 1'b1;
        end
      end else begin
        count_ok = 1'b1;
      end

      if (en && count_ok) begin
        if (tc) begin
          case (mode_e)
            CNT_SAT: begin
              count_d = up_dn ? up_clamp : count_q;
              sat_d   = 1'b1;
            end
            CNT_ONESHOT: begin
              count_d = up_dn ? up_clamp : count_q;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
            default: begin
              count_d = up_dn ? '0 : max_val;
              wrap_d  = 1'b1;
            end
          endcase
        end else if (up_dn) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;
  assign done  = done_q;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed bench for prog_mod_counter (WIDTH=4) with hand-computed expectations.
module tb_prog_mod_counter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up_dn;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             sat;
  logic             done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  prog_mod_counter #(
    .WIDTH     (WIDTH),
    .RESET_VAL (4'd0)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .sat      (sat),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int unsigned c, input int unsigned w,
                             input int unsigned s, input int unsigned d);
    check({tag, ".count"}, count, c);
    check({tag, ".wrap"},  wrap,  w);
    check({tag, ".sat"},   sat,   s);
    check({tag, ".done"},  done,  d);
  endtask

  int unsigned exp_up[6]   = '{1, 2, 3, 4, 5, 0};
  int unsigned exp_wrap[6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    mode     = 2'b00;
    load     = 1'b0;
    load_val = '0;
    max_val  = 4'd10;
    step();
    check_state("reset", 0, 0, 0, 0);

    // 1: reset mid-count at 7 overrides en
    rst_n = 1'b1; load = 1'b1; load_val = 4'd7;
    step();
    check("t1.load7", count, 7);
    load = 1'b0; en = 1'b1; rst_n = 1'b0;
    step();
    check_state("t1.rst", 0, 0, 0, 0);
    rst_n = 1'b1; en = 1'b0;

    // 2: WRAP up, max 5
    max_val = 4'd5; en = 1'b1; up_dn = 1'b1; mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t2.count%0d", i), count, exp_up[i]);
      check($sformatf("t2.wrap%0d", i), wrap, exp_wrap[i]);
    end
    en = 1'b0;
    step();
    check_state("t2.idle", 0, 0, 0, 0);

    // 3: WRAP down, max 9, from 1
    max_val = 4'd9; load_val = 4'd1; load = 1'b1;
    step();
    check("t3.load", count, 1);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    step();
    check_state("t3.d0", 0, 0, 0, 0);
    check("t3.tc0", tc, 1);
    step();
    check_state("t3.d9", 9, 1, 0, 0);
    step();
    check_state("t3.d8", 8, 0, 0, 0);
    en = 1'b0;

    // 4: SAT up, max 3, from 2
    mode = 2'b01; max_val = 4'd3; load_val = 4'd2; load = 1'b1; up_dn = 1'b1;
    step();
    check("t4.load", count, 2);
    load = 1'b0; en = 1'b1;
    step();
    check_state("t4.c3", 3, 0, 0, 0);
    check("t4.tc", tc, 1);
    step();
    check_state("t4.sat1", 3, 0, 1, 0);
    step();
    check_state("t4.sat2", 3, 0, 1, 0);
    en = 1'b0;
    step();
    check("t4.sticky", sat, 1);
    load_val = 4'd12; load = 1'b1;
    step();
    check_state("t4.clamp", 3, 0, 0, 0);
    load = 1'b0;

    // 5: ONESHOT up, max 4, from 0
    mode = 2'b10; max_val = 4'd4; load_val = 4'd0; load = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_state($sformatf("t5.c%0d", i), i, 0, 0, 0);
    end
    step();
    check_state("t5.done", 4, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_state($sformatf("t5.frz%0d", i), 4, 0, 0, 1);
    end
    load_val = 4'd2; load = 1'b1;
    step();
    check_state("t5.reload", 2, 0, 0, 0);
    load = 1'b0;
    step();
    check("t5.r3", count, 3);
    step();
    check("t5.r4", count, 4);
    step();
    check("t5.done2", done, 1);
    // leaving ONESHOT while frozen releases done
    en = 1'b0; mode = 2'b00;
    step();
    check_state("t5.exit", 4, 0, 0, 0);

    // max_val == 0: count pinned at 0, every enabled edge pulses wrap
    max_val = 4'd0; load_val = 4'd5; load = 1'b1;
    step();
    check("mz.load", count, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();
    check_state("mz.up", 0, 1, 0, 0);
    up_dn = 1'b0;
    step();
    check_state("mz.dn", 0, 1, 0, 0);
    en = 1'b0;

    // reserved mode acts as WRAP
    mode = 2'b11; max_val = 4'd2; load_val = 4'd2; load = 1'b1; up_dn = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check_state("rsvd", 0, 1, 0, 0);
    en = 1'b0; mode = 2'b00;

    // 6: load beats en; lowering max_val below count forces terminal
    max_val = 4'd10; load_val = 4'd6; load = 1'b1;
    step();
    check("t6.load6", count, 6);
    load_val = 4'd1; en = 1'b1;
    step();
    check("t6.loadwins", count, 1);
    en = 1'b0; load_val = 4'd8;
    step();
    check("t6.load8", count, 8);
    load = 1'b0; max_val = 4'd3;
    #1;
    check("t6.tc", tc, 1);
    en = 1'b1; up_dn = 1'b1;
    step();
    check_state("t6.wrap", 0, 1, 0, 0);
    en = 1'b0;
    step();
    check("t6.wrapclr", wrap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
